ofdm_tx_frame_sched: RTL and testbench
======================================

Name: ofdm_tx_frame_sched

Overview:
Burst sequencer and arbiter in front of the OFDM Tx input buffer (224-bit frame in, serial bit out). Each burst it feeds PRE_FRAMES preamble frames from the preamble source, then burst_len data frames from the data source. It hands exactly one frame to the buffer, waits until all FRAME_BITS bits have been drained, inserts a guard gap, and only then loads the next frame. Driven by the PS control registers (start/abort/burst_len).

Parameters:
FRAME_BITS, 224, frame width and number of bit beats per frame
PRE_FRAMES, 2, preamble frames per burst (>=1)
GAP_CYCLES, 4, idle cycles between frames (>=1)
LEN_W, 8, width of burst_len and frame_cnt

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a burst when idle
abort  in  1  pulse; terminates the burst
burst_len  in  LEN_W  data frames per burst, sampled on accepted start
pre_din  in  FRAME_BITS  preamble frame
pre_valid  in  1  preamble frame available
pre_ready  out  1  preamble frame taken this cycle
dat_din  in  FRAME_BITS  data frame
dat_valid  in  1  data frame available
dat_ready  out  1  data frame taken this cycle
buf_din  out  FRAME_BITS  frame to buffer (registered)
buf_din_valid  out  1  frame offered to buffer
buf_din_wready  in  1  buffer accept strobe
buf_dout_valid  in  1  buffer bit valid (monitored)
buf_dout_rready  in  1  consumer bit ready (monitored)
busy  out  1  burst in progress
done  out  1  one-cycle pulse at normal burst completion
frame_cnt  out  LEN_W  frames fully drained in current or last burst

Behaviour:
- Reset (sync, active-high) -> state IDLE; buf_din=0, buf_din_valid=0, pre_ready=0, dat_ready=0, busy=0, done=0, frame_cnt=0; counters cleared. Reset mid-burst discards the frame in flight.
- Clock is clk. Reset is reset: synchronous, active-high.
- Internal phase flag: PRE or DAT. pre_cnt counts PRE_FRAMES; dat_left is loaded from burst_len on start. bit_cnt is clog2(FRAME_BITS+1) wide. gap_cnt counts GAP_CYCLES.
- IDLE: start=1 -> FETCH next cycle. In the same edge: busy<=1, frame_cnt<=0, phase<=PRE, dat_left<=burst_len. start while not IDLE is ignored.
- FETCH: the selected source's ready is combinationally 1 (pre_ready in PRE, dat_ready in DAT); the other ready is 0.
  - On src_valid&&src_ready: buf_din<=src_din, buf_din_valid<=1, state->LOAD.
  - With src_valid low, the block waits indefinitely.
- LOAD: buf_din_valid held at 1 and buf_din stable until buf_din_wready=1 is sampled. Then buf_din_valid<=0, bit_cnt<=0, state->DRAIN.
- DRAIN: bit_cnt increments on every cycle with buf_dout_valid&&buf_dout_rready. On the beat that makes bit_cnt=FRAME_BITS: frame_cnt<=frame_cnt+1 (wraps mod 2^LEN_W), gap_cnt<=0, state->GAP.
- GAP: runs GAP_CYCLES cycles, then picks the next state:
  - PRE with pre_cnt+1<PRE_FRAMES -> FETCH (PRE).
  - PRE finished and dat_left>0 -> phase<=DAT, FETCH.
  - DAT with dat_left-1>0 -> FETCH.
  - Otherwise -> DONE.
  - pre_cnt/dat_left update on leaving DRAIN.
- DONE: done=1 for exactly one cycle, busy<=0, -> IDLE. frame_cnt holds until the next start.
- burst_len=0: preamble frames only, then DONE.
- abort=1 in any non-IDLE state: next cycle IDLE, buf_din_valid=0, readies 0, busy=0, no done pulse.
  - abort has priority over start and over all transitions.
  - abort in LOAD/DRAIN leaves the buffer contents as they are; the system must reset the buffer.
- Simultaneous abort and source handshake in FETCH: the handshake is not completed. Ready is forced to 0 when abort=1.
- Beats seen outside DRAIN are ignored.
- Latency: start -> first pre_ready = 1 cycle; source handshake -> buf_din_valid = 1 cycle.

Decomposition:
- Shared package ofdm_tx_pkg holds:
  - FRAME_BITS default;
  - state enum (IDLE, FETCH, LOAD, DRAIN, GAP, DONE);
  - phase enum (PRE, DAT).
- One sub-module, ofdm_beat_counter: a parameterised up-counter with clear, enable and terminal-count flag. It is used for both bit_cnt and gap_cnt.

Test Plan:
- Reset, then start with burst_len=3, sources always valid, consumer always ready.
  - 2 pre_ready pulses, then 3 dat_ready pulses, in that order.
  - done pulses once; frame_cnt=5; busy lasts 5 frames × (224 beats + gaps).
- burst_len=0 -> exactly 2 preamble frames, no dat_ready, done pulse, frame_cnt=2.
- Buffer wready delayed 10 cycles in LOAD -> buf_din_valid stays 1 and buf_din stable all 10 cycles; no second source handshake.
- Consumer throttled (rready 50%) -> next FETCH only after 224 counted beats + 4 gap cycles; beats during GAP are not counted.
- abort asserted at beat 100 of a data frame -> IDLE next cycle, busy=0, no done pulse; a new start re-runs from preamble.
- start pulsed while busy, plus reset asserted during DRAIN -> start is ignored; after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared types for the OFDM Tx frame scheduler: default frame width,
// sequencer state encoding and burst phase.
package ofdm_tx_pkg;

  localparam int FRAME_BITS_DEF = 224;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic {
    PH_PRE = 1'b0,
    PH_DAT = 1'b1
  } phase_e;

endpackage

// File: rtl/ofdm_beat_counter.sv
// Up-counter with synchronous clear and enable. tc flags the enabled step
// that brings the count from TERM-1 to TERM.
module ofdm_beat_counter #(
  parameter int TERM  = 224,
  parameter int WIDTH = $clog2(TERM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = en && (cnt_q == WIDTH'(TERM - 1));

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// Burst sequencer in front of the OFDM Tx input buffer. Per burst it feeds
// PRE_FRAMES preamble frames then burst_len data frames, one at a time:
// fetch a frame, offer it to the buffer, wait for all FRAME_BITS bits to be
// drained by the consumer, idle for GAP_CYCLES, then fetch the next.
//
// Handshakes: a source frame moves on a cycle where its valid and ready are
// both 1 (ready is only ever high in FETCH and is dropped by abort); the
// buffer takes buf_din on a cycle where buf_din_valid and buf_din_wready are
// both 1; a bit beat is any cycle with buf_dout_valid and buf_dout_rready,
// counted only while draining.
module ofdm_tx_frame_sched
  import ofdm_tx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int PRE_FRAMES = 2,
  parameter int GAP_CYCLES = 4,
  parameter int LEN_W      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [LEN_W-1:0]                  burst_len,
  input  logic [FRAME_BITS-1:0]             pre_din,
  input  logic                              pre_valid,
  output logic                              pre_ready,
  input  logic [FRAME_BITS-1:0]             dat_din,
  input  logic                              dat_valid,
  output logic                              dat_ready,
  output logic [FRAME_BITS-1:0]             buf_din,
  output logic                              buf_din_valid,
  input  logic                              buf_din_wready,
  input  logic                              buf_dout_valid,
  input  logic                              buf_dout_rready,
  output logic                              busy,
  output logic                              done,
  output logic [LEN_W-1:0]                  frame_cnt,
  output state_e                            dbg_state,
  output logic [$clog2(FRAME_BITS+1)-1:0]   dbg_bit_cnt,
  output logic [$clog2(GAP_CYCLES+1)-1:0]   dbg_gap_cnt
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int PRE_W = $clog2(PRE_FRAMES + 1);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]      dat_left_q, dat_left_d;
  logic [FRAME_BITS-1:0] buf_din_q, buf_din_d;
  logic                  buf_din_valid_q, buf_din_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_W-1:0]      frame_cnt_q, frame_cnt_d;

  logic                  beat;
  logic                  fetch_rdy;
  logic                  src_valid;
  logic [FRAME_BITS-1:0] src_din;
  logic                  bit_clr, bit_en, bit_tc;
  logic                  gap_clr, gap_en, gap_tc;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;

  // Source selection and handshake qualifiers.
  always_comb begin
    beat      = buf_dout_valid && buf_dout_rready;
    fetch_rdy = (state_q == ST_FETCH) && !abort;
    src_valid = (phase_q == PH_PRE) ? pre_valid : dat_valid;
    src_din   = (phase_q == PH_PRE) ? pre_din : dat_din;
    pre_ready = fetch_rdy && (phase_q == PH_PRE);
    dat_ready = fetch_rdy && (phase_q == PH_DAT);
    bit_clr   = (state_q == ST_LOAD) && buf_din_wready;
    bit_en    = (state_q == ST_DRAIN) && beat;
    gap_clr   = bit_tc;
    gap_en    = (state_q == ST_GAP);
  end

  ofdm_beat_counter #(
    .TERM  (FRAME_BITS),
    .WIDTH (BIT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bit_clr),
    .en    (bit_en),
    .cnt   (bit_cnt),
    .tc    (bit_tc)
  );

  ofdm_beat_counter #(
    .TERM  (GAP_CYCLES),
    .WIDTH (GAP_W)
  ) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (gap_clr),
    .en    (gap_en),
    .cnt   (gap_cnt),
    .tc    (gap_tc)
  );

  // Sequencer next-state: abort from any active state wins over everything.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    pre_cnt_d       = pre_cnt_q;
    dat_left_d      = dat_left_q;
    buf_din_d       = buf_din_q;
    buf_din_valid_d = buf_din_valid_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    frame_cnt_d     = frame_cnt_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d         = ST_IDLE;
      buf_din_valid_d = 1'b0;
      busy_d          = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d     = ST_FETCH;
            busy_d      = 1'b1;
            frame_cnt_d = '0;
            phase_d     = PH_PRE;
            pre_cnt_d   = '0;
            dat_left_d  = burst_len;
          end
        end
        ST_FETCH: begin
          if (src_valid) begin
            buf_din_d       = src_din;
            buf_din_valid_d = 1'b1;
            state_d         = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (buf_din_wready) begin
            buf_din_valid_d = 1'b0;
            state_d         = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (bit_tc) begin
            frame_cnt_d = frame_cnt_q + LEN_W'(1);
            if (phase_q == PH_PRE) begin
              pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end else begin
              dat_left_d = dat_left_q - LEN_W'(1);
            end
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          // Frame counters were already advanced when the drain finished.
          if (gap_tc) begin
            if ((phase_q == PH_PRE) && (pre_cnt_q < PRE_W'(PRE_FRAMES))) begin
              state_d = ST_FETCH;
            end else if (dat_left_q != '0) begin
              phase_d = PH_DAT;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      phase_q         <= PH_PRE;
      pre_cnt_q       <= '0;
      dat_left_q      <= '0;
      buf_din_q       <= '0;
      buf_din_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      frame_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      pre_cnt_q       <= pre_cnt_d;
      dat_left_q      <= dat_left_d;
      buf_din_q       <= buf_din_d;
      buf_din_valid_q <= buf_din_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      frame_cnt_q     <= frame_cnt_d;
    end
  end

  assign buf_din       = buf_din_q;
  assign buf_din_valid = buf_din_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = frame_cnt_q;
  assign dbg_state     = state_q;
  assign dbg_bit_cnt   = bit_cnt;
  assign dbg_gap_cnt   = gap_cnt;

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Testbench for ofdm_tx_frame_sched: random frames, random throttling of
// sources, buffer and consumer, checked against a frame-level burst model.
module tb_ofdm_tx_frame_sched;
  import ofdm_tx_pkg::*;

  localparam int FB = 224;
  localparam int PF = 2;
  localparam int GC = 4;
  localparam int LW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset, start, abort;
  logic [LW-1:0] burst_len;
  logic [FB-1:0] pre_din, dat_din;
  logic          pre_valid, dat_valid, pre_ready, dat_ready;
  logic [FB-1:0] buf_din;
  logic          buf_din_valid, buf_din_wready, buf_dout_valid, buf_dout_rready;
  logic          busy, done;
  logic [LW-1:0] frame_cnt;
  state_e        dbg_state;
  logic [7:0]    dbg_bit_cnt;
  logic [2:0]    dbg_gap_cnt;

  ofdm_tx_frame_sched #(
    .FRAME_BITS (FB), .PRE_FRAMES (PF), .GAP_CYCLES (GC), .LEN_W (LW)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .burst_len (burst_len),
    .pre_din (pre_din), .pre_valid (pre_valid), .pre_ready (pre_ready),
    .dat_din (dat_din), .dat_valid (dat_valid), .dat_ready (dat_ready),
    .buf_din (buf_din), .buf_din_valid (buf_din_valid),
    .buf_din_wready (buf_din_wready),
    .buf_dout_valid (buf_dout_valid), .buf_dout_rready (buf_dout_rready),
    .busy (busy), .done (done), .frame_cnt (frame_cnt),
    .dbg_state (dbg_state), .dbg_bit_cnt (dbg_bit_cnt), .dbg_gap_cnt (dbg_gap_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // stimulus knobs
  int svalid_pct = 100;
  int dvalid_pct = 100;
  int rready_pct = 100;
  int wr_delay   = 0;
  int wcnt       = 0;

  function automatic logic [FB-1:0] rand_frame();
    logic [FB-1:0] f;
    for (int i = 0; i < FB / 32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  function automatic logic pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // ---------------- driver: sources, buffer, consumer ----------------
  initial begin
    pre_din = '0; dat_din = '0; pre_valid = 1'b0; dat_valid = 1'b0;
    buf_din_wready = 1'b0; buf_dout_valid = 1'b0; buf_dout_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pre_din         = rand_frame();
      dat_din         = rand_frame();
      pre_valid       = pct(svalid_pct);
      dat_valid       = pct(svalid_pct);
      buf_dout_valid  = pct(dvalid_pct);
      buf_dout_rready = pct(rready_pct);
      if (buf_din_wready) begin
        buf_din_wready = 1'b0;
      end else if (buf_din_valid) begin
        if (wcnt >= wr_delay) buf_din_wready = 1'b1;
        else wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [FB-1:0] exp_q[$];
  int            hs_log[$];
  int            done_cnt = 0;
  bit            drain_active = 0;
  int            beats = 0;
  bit            cur_dat = 0;
  bit            pending_gap = 0;
  int            last_beat_cyc = 0;
  bit            prev_valid = 0;
  logic [FB-1:0] prev_din = '0;
  logic [FB-1:0] exp_f;

  always @(negedge clk) begin
    if (reset || abort) begin
      drain_active = 0;
      pending_gap  = 0;
      prev_valid   = 0;
      exp_q.delete();
    end else begin
      if (pre_ready || dat_ready) begin
        n_vec++;
        if ((pre_ready && dat_ready) || drain_active || buf_din_valid) begin
          n_err++;
          $display("FAIL ready_excl: pre_ready=%0b dat_ready=%0b draining=%0b valid=%0b required single ready with no frame in flight",
                   pre_ready, dat_ready, drain_active, buf_din_valid);
        end
      end
      if ((pre_ready || dat_ready || done) && pending_gap) begin
        n_vec++;
        if (cyc - last_beat_cyc !== GC + 1) begin
          n_err++;
          $display("FAIL gap_timing: %0d cycles after last beat, required %0d", cyc - last_beat_cyc, GC + 1);
        end
        pending_gap = 0;
      end
      if (done) done_cnt++;
      if (pre_ready && pre_valid) begin
        hs_log.push_back(0); exp_q.push_back(pre_din); cur_dat = 0;
      end
      if (dat_ready && dat_valid) begin
        hs_log.push_back(1); exp_q.push_back(dat_din); cur_dat = 1;
      end
      if (buf_din_valid) begin
        n_vec++;
        if (!prev_valid) begin
          exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : ~buf_din;
          if (buf_din !== exp_f) begin
            n_err++;
            $display("FAIL buf_din: got %h required %h", buf_din, exp_f);
          end
        end else if (buf_din !== prev_din) begin
          n_err++;
          $display("FAIL buf_din_stable: got %h required %h", buf_din, prev_din);
        end
        prev_din = buf_din;
      end
      prev_valid = buf_din_valid;
      if (drain_active && buf_dout_valid && buf_dout_rready) begin
        beats++;
        if (beats == FB) begin
          drain_active  = 0;
          pending_gap   = 1;
          last_beat_cyc = cyc;
        end
      end
      if (buf_din_valid && buf_din_wready) begin
        drain_active = 1;
        beats        = 0;
      end
    end
  end

  // ---------------- tasks ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; burst_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({buf_din_valid, pre_ready, dat_ready, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %05b required 00000", {buf_din_valid, pre_ready, dat_ready, busy, done});
    end
    n_vec++;
    if (buf_din !== '0) begin
      n_err++; $display("FAIL reset_buf_din: got %h required 0", buf_din);
    end
    n_vec++;
    if (frame_cnt !== '0) begin
      n_err++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Run one burst to completion and check it against the burst model.
  // poke > 0 pulses an extra start (with a different burst_len) after
  // that many drained beats of the first frame.
  task automatic run_burst(input int len, input int poke, input string tag, output int busy_cyc);
    int  k;
    bit  poked;
    hs_log.delete();
    done_cnt = 0;
    poked    = 0;
    @(posedge clk); #1;
    burst_len = LW'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; burst_len = LW'($urandom_range(0, 255));
    @(negedge clk);
    n_vec++;
    if (pre_ready !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_start_lat: pre_ready=%0b busy=%0b required 1 1", tag, pre_ready, busy);
    end
    busy_cyc = 0;
    for (k = 0; k < 30000; k++) begin
      if (!busy) break;
      busy_cyc++;
      if (poke > 0 && !poked && drain_active && beats >= poke) begin
        start = 1'b1; burst_len = 8'd9; poked = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (busy) begin
      n_err++; $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", tag, k);
    end
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++; $display("FAIL %s_done_cnt: got %0d required 1", tag, done_cnt);
    end
    n_vec++;
    if (frame_cnt !== LW'(PF + len)) begin
      n_err++; $display("FAIL %s_frame_cnt: got %0d required %0d", tag, frame_cnt, LW'(PF + len));
    end
    n_vec++;
    if (hs_log.size() !== PF + len) begin
      n_err++; $display("FAIL %s_hs_count: got %0d required %0d", tag, hs_log.size(), PF + len);
    end else begin
      for (int i = 0; i < PF + len; i++) begin
        n_vec++;
        if (hs_log[i] !== ((i < PF) ? 0 : 1)) begin
          n_err++; $display("FAIL %s_hs_order: frame %0d source %0d required %0d", tag, i, hs_log[i], (i < PF) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_basic();
    int bc;
    svalid_pct = 100; dvalid_pct = 100; rready_pct = 100; wr_delay = 0;
    run_burst(3, 0, "basic", bc);
    n_vec++;
    if (bc !== (PF + 3) * (2 + FB + GC) + 1) begin
      n_err++; $display("FAIL basic_busy_len: got %0d required %0d", bc, (PF + 3) * (2 + FB + GC) + 1);
    end
  endtask

  task automatic test_zero_len();
    int bc;
    run_burst(0, 0, "zero", bc);
    n_vec++;
    if (bc !== PF * (2 + FB + GC) + 1) begin
      n_err++; $display("FAIL zero_busy_len: got %0d required %0d", bc, PF * (2 + FB + GC) + 1);
    end
  endtask

  task automatic test_wready_delay();
    int bc;
    wr_delay = 10;
    run_burst(1, 0, "wdelay", bc);
    n_vec++;
    if (bc !== (PF + 1) * (12 + FB + GC) + 1) begin
      n_err++; $display("FAIL wdelay_busy_len: got %0d required %0d", bc, (PF + 1) * (12 + FB + GC) + 1);
    end
    wr_delay = 0;
  endtask

  task automatic test_throttle();
    int bc;
    svalid_pct = 60; dvalid_pct = 80; rready_pct = 50; wr_delay = 2;
    run_burst(2, 0, "throttle", bc);
    svalid_pct = 100; dvalid_pct = 100; rready_pct = 100; wr_delay = 0;
  endtask

  task automatic test_abort();
    int k;
    int bc;
    done_cnt = 0;
    @(posedge clk); #1;
    burst_len = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (drain_active && cur_dat && beats >= 100) break;
    end
    n_vec++;
    if (k >= 5000) begin
      n_err++; $display("FAIL abort_reach: beat 100 of data frame not reached, required reached");
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, buf_din_valid, pre_ready, dat_ready} !== 4'b0) begin
      n_err++; $display("FAIL abort_outputs: got %04b required 0000", {busy, buf_din_valid, pre_ready, dat_ready});
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL abort_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (done_cnt !== 0) begin
      n_err++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt);
    end
    run_burst(1, 0, "rerun", bc);
  endtask

  task automatic test_start_busy_and_reset();
    int k;
    int bc;
    run_burst(2, 50, "busy_start", bc);
    @(posedge clk); #1;
    burst_len = 8'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (drain_active && beats >= 30) break;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, buf_din_valid, pre_ready, dat_ready, done} !== 5'b0 || buf_din !== '0 || frame_cnt !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: ctrl=%05b frame_cnt=%0d buf_din_zero=%0b required 00000 0 1",
               {busy, buf_din_valid, pre_ready, dat_ready, done}, frame_cnt, buf_din == '0);
    end
    n_vec++;
    if (dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL mid_reset_state: got %0d required %0d", dbg_state, ST_IDLE);
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if ({busy, pre_ready, dat_ready, buf_din_valid} !== 4'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL post_reset_idle: ctrl=%04b state=%0d required 0000 %0d",
                        {busy, pre_ready, dat_ready, buf_din_valid}, dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wready_delay();
    test_throttle();
    test_abort();
    test_start_busy_and_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
